id_config_loader: RTL and testbench



---
 rtl/id_config_loader.sv | 178 +++++++++++++++++
 tb/tb_id_config_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_config_loader.sv
// Streams generated filter/ifmap/ipsum/opsum X and Y IDs to the PE-array
// multicast controllers over a valid/ready config bus, one ID per beat.
module id_config_loader #(
  parameter int NUM_PE = 48,
  parameter int XID_W  = 5,
  parameter int YID_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       PE_ARRAY_H,
  input  logic [3:0]       PE_ARRAY_W,
  input  logic             x_done,
  input  logic             y_done,
  input  logic [XID_W-1:0] filter_XID [0:NUM_PE-1],
  input  logic [XID_W-1:0] ifmap_XID  [0:NUM_PE-1],
  input  logic [XID_W-1:0] ipsum_XID  [0:NUM_PE-1],
  input  logic [XID_W-1:0] opsum_XID  [0:NUM_PE-1],
  input  logic [YID_W-1:0] filter_YID [0:NUM_PE-1],
  input  logic [YID_W-1:0] ifmap_YID  [0:NUM_PE-1],
  input  logic [YID_W-1:0] ipsum_YID  [0:NUM_PE-1],
  input  logic [YID_W-1:0] opsum_YID  [0:NUM_PE-1],
  output logic             cfg_valid,
  input  logic             cfg_ready,
  output logic [1:0]       cfg_type,
  output logic             cfg_is_y,
  output logic [2:0]       cfg_row,
  output logic [3:0]       cfg_col,
  output logic [XID_W-1:0] cfg_id,
  output logic             busy,
  output logic             load_done,
  output logic             cfg_err
);
  localparam int IDX_W = $clog2(NUM_PE);

  typedef enum logic [2:0] {IDLE, WAIT_ID, LOAD_X, LOAD_Y, DONE} state_t;

  state_t           state, state_d;
  logic [2:0]       h_q, h_d;
  logic [3:0]       w_q, w_d;
  logic [1:0]       typ_d;
  logic [2:0]       row_d;
  logic [3:0]       col_d;
  logic             is_y_d, valid_d, err_d, load_pl;
  logic [XID_W-1:0] id_nx;
  logic [7:0]       area;
  logic             legal, accept, last_row, last_col;

  assign area     = 8'(PE_ARRAY_H) * 8'(PE_ARRAY_W);
  assign legal    = (|PE_ARRAY_H) && (|PE_ARRAY_W) && (area <= 8'(NUM_PE));
  assign accept   = cfg_valid & cfg_ready;
  assign last_row = (cfg_row == h_q - 3'd1);
  assign last_col = (cfg_col == w_q - 4'd1);
  assign busy      = (state != IDLE);
  assign load_done = (state == DONE);

  // Next-state and next-beat counters; the cfg_* registers double as the
  // walk counters, so they only move when a beat is accepted.
  always_comb begin
    state_d = state;
    h_d     = h_q;
    w_d     = w_q;
    typ_d   = cfg_type;
    row_d   = cfg_row;
    col_d   = cfg_col;
    is_y_d  = cfg_is_y;
    valid_d = cfg_valid;
    err_d   = 1'b0;
    load_pl = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (legal) begin
            state_d = WAIT_ID;
            h_d     = PE_ARRAY_H;
            w_d     = PE_ARRAY_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_ID: begin
        if (x_done && y_done) begin
          state_d = LOAD_X;
          typ_d   = 2'd0;
          row_d   = 3'd0;
          col_d   = 4'd0;
          is_y_d  = 1'b0;
          valid_d = 1'b1;
          load_pl = 1'b1;
        end
      end
      LOAD_X: begin
        if (accept) begin
          load_pl = 1'b1;
          if (!last_col) begin
            col_d = cfg_col + 4'd1;
          end else begin
            col_d = 4'd0;
            if (!last_row) begin
              row_d = cfg_row + 3'd1;
            end else begin
              row_d = 3'd0;
              typ_d = cfg_type + 2'd1;
              if (cfg_type == 2'd3) begin
                state_d = LOAD_Y;
                is_y_d  = 1'b1;
              end
            end
          end
        end
      end
      LOAD_Y: begin
        if (accept) begin
          if (!last_row) begin
            row_d   = cfg_row + 3'd1;
            load_pl = 1'b1;
          end else begin
            row_d = 3'd0;
            typ_d = cfg_type + 2'd1;
            if (cfg_type == 2'd3) begin
              state_d = DONE;
              valid_d = 1'b0;
              is_y_d  = 1'b0;
            end else begin
              load_pl = 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ID fetch for the beat about to be presented.
  logic [IDX_W-1:0] idx, yidx;
  logic [XID_W-1:0] xsel;
  logic [YID_W-1:0] ysel;

  always_comb begin
    idx  = IDX_W'(row_d) * IDX_W'(w_q) + IDX_W'(col_d);
    yidx = IDX_W'(row_d);
    case (typ_d)
      2'd0:    begin xsel = filter_XID[idx]; ysel = filter_YID[yidx]; end
      2'd1:    begin xsel = ifmap_XID[idx];  ysel = ifmap_YID[yidx];  end
      2'd2:    begin xsel = ipsum_XID[idx];  ysel = ipsum_YID[yidx];  end
      default: begin xsel = opsum_XID[idx];  ysel = opsum_YID[yidx];  end
    endcase
    id_nx = is_y_d ? XID_W'(ysel) : xsel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      h_q       <= '0;
      w_q       <= '0;
      cfg_valid <= 1'b0;
      cfg_type  <= '0;
      cfg_is_y  <= 1'b0;
      cfg_row   <= '0;
      cfg_col   <= '0;
      cfg_id    <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_d;
      h_q       <= h_d;
      w_q       <= w_d;
      cfg_valid <= valid_d;
      cfg_type  <= typ_d;
      cfg_is_y  <= is_y_d;
      cfg_row   <= row_d;
      cfg_col   <= col_d;
      cfg_err   <= err_d;
      if (load_pl) cfg_id <= id_nx;
    end
  end
endmodule

// File: tb/tb_id_config_loader.sv
// Bench for id_config_loader: table of geometry/handshake scenarios plus
// randomized loads, every beat checked against a nested-loop reference walk.
module tb_id_config_loader;
  localparam int NUM_PE = 48;

  logic       clk = 1'b0;
  logic       rst_n, start, x_done, y_done, cfg_ready;
  logic [2:0] PE_ARRAY_H;
  logic [3:0] PE_ARRAY_W;
  logic [4:0] filter_XID [0:NUM_PE-1];
  logic [4:0] ifmap_XID  [0:NUM_PE-1];
  logic [4:0] ipsum_XID  [0:NUM_PE-1];
  logic [4:0] opsum_XID  [0:NUM_PE-1];
  logic [2:0] filter_YID [0:NUM_PE-1];
  logic [2:0] ifmap_YID  [0:NUM_PE-1];
  logic [2:0] ipsum_YID  [0:NUM_PE-1];
  logic [2:0] opsum_YID  [0:NUM_PE-1];
  logic       cfg_valid, cfg_is_y, busy, load_done, cfg_err;
  logic [1:0] cfg_type;
  logic [2:0] cfg_row;
  logic [3:0] cfg_col;
  logic [4:0] cfg_id;

  id_config_loader #(.NUM_PE(NUM_PE), .XID_W(5), .YID_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .PE_ARRAY_H(PE_ARRAY_H), .PE_ARRAY_W(PE_ARRAY_W),
    .x_done(x_done), .y_done(y_done),
    .filter_XID(filter_XID), .ifmap_XID(ifmap_XID),
    .ipsum_XID(ipsum_XID), .opsum_XID(opsum_XID),
    .filter_YID(filter_YID), .ifmap_YID(ifmap_YID),
    .ipsum_YID(ipsum_YID), .opsum_YID(opsum_YID),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_type(cfg_type),
    .cfg_is_y(cfg_is_y), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_id(cfg_id), .busy(busy), .load_done(load_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] t;
    logic       y;
    logic [2:0] r;
    logic [3:0] c;
    logic [4:0] id;
  } beat_t;

  typedef struct {
    logic [2:0] h;
    logic [3:0] w;
    int         rdy;    // percent chance cfg_ready is high
    int         ydly;   // cycles y_done is held low after start
    int         abort;  // beat index at which reset is applied, -1 = none
    bit         err;    // expected cfg_err pulse
    int         beats;  // expected accepted beats
  } vec_t;

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  beat_t got_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic set_ids(input bit rnd);
    for (int i = 0; i < NUM_PE; i++) begin
      filter_XID[i] = rnd ? 5'($urandom) : 5'(i % 32);
      ifmap_XID[i]  = rnd ? 5'($urandom) : 5'(i % 32);
      ipsum_XID[i]  = rnd ? 5'($urandom) : 5'(i % 32);
      opsum_XID[i]  = rnd ? 5'($urandom) : 5'(i % 32);
      filter_YID[i] = rnd ? 3'($urandom) : 3'(i % 8);
      ifmap_YID[i]  = rnd ? 3'($urandom) : 3'(i % 8);
      ipsum_YID[i]  = rnd ? 3'($urandom) : 3'(i % 8);
      opsum_YID[i]  = rnd ? 3'($urandom) : 3'(i % 8);
    end
  endtask

  function automatic logic [4:0] get_x(input int t, input int i);
    case (t)
      0: return filter_XID[i];
      1: return ifmap_XID[i];
      2: return ipsum_XID[i];
      default: return opsum_XID[i];
    endcase
  endfunction

  function automatic logic [2:0] get_y(input int t, input int r);
    case (t)
      0: return filter_YID[r];
      1: return ifmap_YID[r];
      2: return ipsum_YID[r];
      default: return opsum_YID[r];
    endcase
  endfunction

  // Reference walk: every X ID in type/row/col order, then every Y ID.
  function automatic void build_exp(input int h, input int w);
    beat_t b;
    exp_q.delete();
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          b = '{t: 2'(t), y: 1'b0, r: 3'(r), c: 4'(c), id: get_x(t, r * w + c)};
          exp_q.push_back(b);
        end
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < h; r++) begin
        b = '{t: 2'(t), y: 1'b1, r: 3'(r), c: 4'd0, id: {2'b00, get_y(t, r)}};
        exp_q.push_back(b);
      end
  endfunction

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"}, cfg_valid, 0);
    chk({nm, "_payload"}, {cfg_type, cfg_is_y, cfg_row, cfg_col, cfg_id}, 0);
    chk({nm, "_status"}, {busy, load_done, cfg_err}, 0);
  endtask

  task automatic do_load(input vec_t v, output int nb, output bit err_seen);
    bit    legal, done_seen;
    int    first_v, last_acc, vcnt;
    bit    prev_stall, rdy;
    beat_t cur, prev;
    legal    = v.h != 0 && v.w != 0 && int'(v.h) * int'(v.w) <= NUM_PE;
    nb       = 0;
    err_seen = 0;
    got_q.delete();
    if (legal) build_exp(v.h, v.w);
    else exp_q.delete();
    PE_ARRAY_H = v.h;
    PE_ARRAY_W = v.w;
    x_done     = 1'b1;
    y_done     = (v.ydly == 0);
    cfg_ready  = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    err_seen = cfg_err;
    if (!legal) begin
      chk("illegal_busy", busy, 0);
      vcnt = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (cfg_valid || busy || cfg_err) vcnt++;
      end
      chk("illegal_quiet_after_pulse", vcnt, 0);
      return;
    end
    chk("legal_no_err", cfg_err, 0);
    first_v    = -1;
    last_acc   = -1;
    prev_stall = 0;
    prev       = '0;
    done_seen  = 0;
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      cur = '{t: cfg_type, y: cfg_is_y, r: cfg_row, c: cfg_col, id: cfg_id};
      chk("busy_during_load", busy, 1);
      if (cyc <= v.ydly) chk("no_valid_before_ids", cfg_valid, 0);
      if (v.ydly > 0 && cyc == v.ydly) y_done = 1'b1;
      if (prev_stall) begin
        chk("stall_valid_held", cfg_valid, 1);
        chk("stall_payload_held", cur, prev);
      end
      if (cfg_valid && first_v < 0) begin
        first_v = cyc;
        chk("first_valid_cycle", cyc, v.ydly + 1);
      end
      if (first_v >= 0 && nb < exp_q.size()) chk("valid_until_last", cfg_valid, 1);
      if (load_done) begin
        done_seen = 1;
        chk("done_after_last_accept", cyc, last_acc + 1);
        chk("beat_count", nb, exp_q.size());
        chk("done_valid_low", cfg_valid, 0);
      end
      if (v.abort >= 0 && nb == v.abort) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("abort_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_done", {load_done, busy, cfg_valid}, 0);
        x_done = 1'b1;
        return;
      end
      rdy = ($urandom_range(99) < v.rdy);
      cfg_ready = rdy;
      if (first_v >= 0 && v.rdy < 100) x_done = ($urandom_range(1) != 0);
      if (cfg_valid && rdy) begin
        if (nb < exp_q.size()) chk("beat", cur, exp_q[nb]);
        else chk("extra_beat", nb, exp_q.size() - 1);
        got_q.push_back(cur);
        nb++;
        last_acc = cyc;
      end
      prev_stall = cfg_valid && !rdy;
      prev       = cur;
      @(posedge clk); #1;
    end
    if (!done_seen) chk("load_done_timeout", 0, 1);
    chk("idle_after_done", {busy, load_done}, 0);
    x_done    = 1'b1;
    cfg_ready = 1'b0;
  endtask

  vec_t tbl[13];
  vec_t rv;
  int   nb;
  bit   es;

  initial begin
    tbl[0]  = '{h: 6, w: 8,  rdy: 100, ydly: 0,  abort: -1,  err: 0, beats: 216};
    tbl[1]  = '{h: 3, w: 4,  rdy: 100, ydly: 0,  abort: -1,  err: 0, beats: 60};
    tbl[2]  = '{h: 6, w: 8,  rdy: 50,  ydly: 0,  abort: -1,  err: 0, beats: 216};
    tbl[3]  = '{h: 6, w: 8,  rdy: 100, ydly: 10, abort: -1,  err: 0, beats: 216};
    tbl[4]  = '{h: 7, w: 8,  rdy: 100, ydly: 0,  abort: -1,  err: 1, beats: 0};
    tbl[5]  = '{h: 6, w: 0,  rdy: 100, ydly: 0,  abort: -1,  err: 1, beats: 0};
    tbl[6]  = '{h: 6, w: 8,  rdy: 100, ydly: 0,  abort: 100, err: 0, beats: 100};
    tbl[7]  = '{h: 6, w: 8,  rdy: 100, ydly: 0,  abort: -1,  err: 0, beats: 216};
    tbl[8]  = '{h: 1, w: 1,  rdy: 70,  ydly: 0,  abort: -1,  err: 0, beats: 8};
    tbl[9]  = '{h: 4, w: 12, rdy: 60,  ydly: 0,  abort: -1,  err: 0, beats: 208};
    tbl[10] = '{h: 5, w: 10, rdy: 100, ydly: 0,  abort: -1,  err: 1, beats: 0};
    tbl[11] = '{h: 1, w: 15, rdy: 100, ydly: 0,  abort: -1,  err: 0, beats: 64};
    tbl[12] = '{h: 0, w: 5,  rdy: 100, ydly: 0,  abort: -1,  err: 1, beats: 0};

    rst_n = 1'b0; start = 1'b0; x_done = 1'b1; y_done = 1'b1; cfg_ready = 1'b0;
    PE_ARRAY_H = 3'd0; PE_ARRAY_W = 4'd0;
    set_ids(0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (i == 1) set_ids(1);
      do_load(tbl[i], nb, es);
      chk($sformatf("vec%0d_err", i), es, tbl[i].err);
      chk($sformatf("vec%0d_beats", i), nb, tbl[i].beats);
      if (i == 0) begin
        chk("full_beat0",   got_q[0],   {2'd0, 1'b0, 3'd0, 4'd0, 5'd0});
        chk("full_beat47",  got_q[47],  {2'd0, 1'b0, 3'd5, 4'd7, 5'd15});
        chk("full_beat191", got_q[191], {2'd3, 1'b0, 3'd5, 4'd7, 5'd15});
        chk("full_beat192", got_q[192], {2'd0, 1'b1, 3'd0, 4'd0, 5'd0});
        chk("full_beat215", got_q[215], {2'd3, 1'b1, 3'd5, 4'd0, 5'd5});
      end
    end

    for (int i = 0; i < 8; i++) begin
      set_ids(1);
      rv.h     = 3'($urandom_range(7));
      rv.w     = 4'($urandom_range(15));
      rv.rdy   = $urandom_range(30, 100);
      rv.ydly  = $urandom_range(3);
      rv.abort = -1;
      rv.err   = !(rv.h != 0 && rv.w != 0 && int'(rv.h) * int'(rv.w) <= NUM_PE);
      rv.beats = rv.err ? 0 : 4 * int'(rv.h) * int'(rv.w) + 4 * int'(rv.h);
      do_load(rv, nb, es);
      chk($sformatf("rnd%0d_err", i), es, rv.err);
      chk($sformatf("rnd%0d_beats", i), nb, rv.beats);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
